vram_arbiter: RTL and testbench

//  Shares one single-port synchronous video RAM between the VGA pixel fetch and a game-logic writer.

---
 rtl/vram_arbiter.sv | 103 ++++++++++
 tb/tb_vram_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between the VGA pixel fetch and a game-logic writer.
//   clk, rst_n                      pixel clock, asynchronous active-low reset
//   i_active, i_x, i_y              timing generator: visible flag, column, row
//   i_hsync, i_vsync                timing generator syncs (active-low)
//   i_wr_valid/i_wr_addr/i_wr_data  writer request; o_wr_ready accepts it
//   o_mem_addr/o_mem_we/o_mem_wdata VRAM port; i_mem_rdata valid 1 cycle after address
//   o_rgb, o_hsync_d, o_vsync_d,    DAC-side pixel and 2-cycle-delayed timing, mutually aligned
//   o_active_d
//   o_frame_done                    1-cycle pulse after the last visible pixel of a frame
//   o_wr_count                      saturating count of writes since the last frame_done
//   o_err_oob                       sticky flag: an out-of-range write was dropped
module vram_arbiter #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int SCALE    = 2,
   parameter int PIX_W    = 8,
   parameter int ADDR_W   = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_active,
   input  logic [9:0]        i_x,
   input  logic [9:0]        i_y,
   input  logic              i_hsync,
   input  logic              i_vsync,
   input  logic              i_wr_valid,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [PIX_W-1:0]  i_wr_data,
   output logic              o_wr_ready,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [PIX_W-1:0]  o_mem_wdata,
   input  logic [PIX_W-1:0]  i_mem_rdata,
   output logic [PIX_W-1:0]  o_rgb,
   output logic              o_hsync_d,
   output logic              o_vsync_d,
   output logic              o_active_d,
   output logic              o_frame_done,
   output logic [15:0]       o_wr_count,
   output logic              o_err_oob
);
   localparam int COLS  = H_ACTIVE >> SCALE;
   localparam int ROWS  = V_ACTIVE >> SCALE;
   localparam int TOTAL = COLS * ROWS;
   logic              w_disp, w_wr, w_oob, w_acc, w_cnt, w_fd;
   logic [ADDR_W-1:0] w_disp_addr, r_addr;
   logic              r_disp1, r_act1, r_hs1, r_vs1, r_act2, r_hs2, r_vs2, r_err;
   logic [PIX_W-1:0]  r_rgb;
   logic [15:0]       r_wr_count;
   // display owns the first pixel of every tile column; the replicated pixels are free for the writer
   assign w_disp      = i_active & (i_x[SCALE-1:0] == '0);
   assign w_wr        = ~w_disp & i_wr_valid;
   assign w_oob       = int'(i_wr_addr) >= TOTAL;
   assign w_acc       = i_wr_valid & o_wr_ready;
   assign w_cnt       = w_acc & ~w_oob;
   assign w_disp_addr = ADDR_W'(ADDR_W'(i_y >> SCALE) * ADDR_W'(COLS) + ADDR_W'(i_x >> SCALE));
   // active just fell on the last visible row
   assign w_fd        = r_act1 & ~i_active & (i_y == 10'(V_ACTIVE - 1));
   assign o_wr_ready  = ~w_disp & rst_n;
   // an out-of-range write is accepted but never reaches the RAM
   assign o_mem_we    = w_wr & ~w_oob & rst_n;
   assign o_mem_wdata = i_wr_data;
   assign o_mem_addr  = w_disp ? w_disp_addr : (w_wr ? i_wr_addr : r_addr);
   assign o_rgb        = r_rgb;
   assign o_hsync_d    = r_hs2;
   assign o_vsync_d    = r_vs2;
   assign o_active_d   = r_act2;
   assign o_frame_done = w_fd;
   assign o_wr_count   = r_wr_count;
   assign o_err_oob    = r_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr     <= '0;
         r_disp1    <= 1'b0;
         r_act1     <= 1'b0;
         r_hs1      <= 1'b1;
         r_vs1      <= 1'b1;
         r_act2     <= 1'b0;
         r_hs2      <= 1'b1;
         r_vs2      <= 1'b1;
         r_rgb      <= '0;
         r_wr_count <= '0;
         r_err      <= 1'b0;
      end else begin
         r_addr  <= o_mem_addr;
         r_disp1 <= w_disp;
         r_act1  <= i_active;
         r_hs1   <= i_hsync;
         r_vs1   <= i_vsync;
         r_act2  <= r_act1;
         r_hs2   <= r_hs1;
         r_vs2   <= r_vs1;
         // replicated pixels hold the last fetched tile value
         r_rgb   <= r_disp1 ? i_mem_rdata : (r_act1 ? r_rgb : '0);
         if (w_fd)
            r_wr_count <= {15'd0, w_cnt};
         else if (w_cnt && r_wr_count != 16'hFFFF)
            r_wr_count <= r_wr_count + 16'd1;
         if (w_acc && w_oob)
            r_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter with a behavioural synchronous VRAM.
module tb_vram_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        act = 1'b0, hs = 1'b1, vs = 1'b1, wv = 1'b0;
   logic [9:0]  xx = '0, yy = '0;
   logic [14:0] wa = '0;
   logic [7:0]  wd = '0;
   logic        wr_ready, mem_we, hsync_d, vsync_d, active_d, frame_done, err_oob;
   logic [14:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata, rgb;
   logic [15:0] wr_count;
   logic [7:0]  vram [0:32767];
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      mem_rdata <= vram[mem_addr];
   end

   vram_arbiter dut (
      .clk(clk), .rst_n(rst_n), .i_active(act), .i_x(xx), .i_y(yy), .i_hsync(hs), .i_vsync(vs),
      .i_wr_valid(wv), .i_wr_addr(wa), .i_wr_data(wd), .o_wr_ready(wr_ready), .o_mem_addr(mem_addr),
      .o_mem_we(mem_we), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_rgb(rgb),
      .o_hsync_d(hsync_d), .o_vsync_d(vsync_d), .o_active_d(active_d), .o_frame_done(frame_done),
      .o_wr_count(wr_count), .o_err_oob(err_oob)
   );

   task automatic drive(input logic r, input logic a, input int xv, input int yv, input logic h,
                        input logic v, input logic w, input int addr, input int d);
      @(negedge clk);
      rst_n = r; act = a; xx = 10'(xv); yy = 10'(yv); hs = h; vs = v; wv = w; wa = 15'(addr); wd = 8'(d);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0, 1, 1, 1, 5, 8'h33);
         checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb got %h exp 00", rgb); end
         checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end
         checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", wr_ready); end
         checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", wr_count); end
         checks++; if ({active_d, err_oob, frame_done, hsync_d, vsync_d} !== 5'b00011)
            begin errors++; $display("FAIL reset_flags got %b exp 00011", {active_d, err_oob, frame_done, hsync_d, vsync_d}); end
      end
      drive(1, 0, 0, 479, 1, 1, 0, 0, 0);
      checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", wr_ready); end
   endtask

   task automatic test_preload;
      drive(1, 0, 0, 479, 1, 1, 1, 0, 8'hE0);
      checks++; if ({wr_ready, mem_we} !== 2'b11) begin errors++; $display("FAIL preload_we got %b exp 11", {wr_ready, mem_we}); end
      drive(1, 0, 0, 479, 1, 1, 1, 1, 8'h1C);
      checks++; if (mem_addr !== 15'd1) begin errors++; $display("FAIL preload_addr got %0d exp 1", mem_addr); end
      drive(1, 0, 0, 479, 1, 1, 0, 0, 0);
      checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL preload_count got %0d exp 2", wr_count); end
   endtask

   task automatic test_pixels;
      int er, ea;
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         drive(1, i < 8, i < 8 ? i : 0, 0, 1, 1, 0, 0, 0);
         er = (i < 2) ? 0 : (i - 2 < 4) ? 8'hE0 : (i - 2 < 8) ? 8'h1C : 0;
         ea = (i >= 2 && i - 2 < 8) ? 1 : 0;
         checks++; if (rgb !== 8'(er)) begin errors++; $display("FAIL pix_rgb[%0d] got %h exp %h", i, rgb, 8'(er)); end
         checks++; if (active_d !== 1'(ea)) begin errors++; $display("FAIL pix_active_d[%0d] got %b exp %b", i, active_d, 1'(ea)); end
      end
   endtask

   task automatic test_reset_midline;
      drive(1, 1, 0, 0, 1, 1, 0, 0, 0);
      for (int x = 1; x < 4; x++) begin
         drive(0, 1, x, 0, 1, 1, 1, 0, 8'hAA);
         checks++; if ({rgb, mem_we, wr_ready, active_d} !== 11'd0)
            begin errors++; $display("FAIL mid_reset[%0d] got rgb=%h we=%b rdy=%b act=%b exp all 0", x, rgb, mem_we, wr_ready, active_d); end
      end
      drive(1, 1, 4, 0, 1, 1, 0, 0, 0);
      checks++; if ({mem_addr, mem_we} !== {15'd1, 1'b0}) begin errors++; $display("FAIL mid_fetch got addr=%0d we=%b exp 1/0", mem_addr, mem_we); end
      drive(1, 1, 5, 0, 1, 1, 0, 0, 0);
      checks++; if (rgb !== 8'h00) begin errors++; $display("FAIL mid_rgb5 got %h exp 00", rgb); end
      drive(1, 1, 6, 0, 1, 1, 0, 0, 0);
      checks++; if (rgb !== 8'h1C || active_d !== 1'b1) begin errors++; $display("FAIL mid_rgb6 got %h/%b exp 1c/1", rgb, active_d); end
      drive(1, 1, 7, 0, 1, 1, 0, 0, 0);
      checks++; if (rgb !== 8'h1C) begin errors++; $display("FAIL mid_rgb7 got %h exp 1c", rgb); end
   endtask

   task automatic test_collision;
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int x = 0; x < 8; x++) begin
         drive(1, 1, x, 0, 1, 1, x == 4 || x == 5, 100, 8'h55);
         if (x == 3) begin
            checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL idle_hold got %0d exp 0", mem_addr); end
         end
         if (x == 4) begin
            checks++; if ({wr_ready, mem_we, mem_addr} !== {2'b00, 15'd1})
               begin errors++; $display("FAIL coll_disp got rdy=%b we=%b addr=%0d exp 0/0/1", wr_ready, mem_we, mem_addr); end
         end
         if (x == 5) begin
            checks++; if ({wr_ready, mem_we, mem_addr, mem_wdata} !== {2'b11, 15'd100, 8'h55})
               begin errors++; $display("FAIL coll_wr got rdy=%b we=%b addr=%0d data=%h exp 1/1/100/55", wr_ready, mem_we, mem_addr, mem_wdata); end
         end
         if (x == 6) begin
            checks++; if (mem_addr !== 15'd100 || wr_count !== 16'd1)
               begin errors++; $display("FAIL coll_after got addr=%0d count=%0d exp 100/1", mem_addr, wr_count); end
         end
      end
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
      drive(1, 1, 400, 0, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
      checks++; if (rgb !== 8'h55) begin errors++; $display("FAIL coll_readback got %h exp 55", rgb); end
   endtask

   task automatic test_back_to_back;
      for (int x = 0; x < 4; x++) drive(1, 1, x, 479, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 479, 1, 1, 0, 0, 0);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL fd1 got %b exp 1", frame_done); end
      drive(1, 0, 0, 479, 1, 1, 0, 0, 0);
      checks++; if (frame_done !== 1'b0 || wr_count !== 16'd0)
         begin errors++; $display("FAIL fd1_after got fd=%b count=%0d exp 0/0", frame_done, wr_count); end
      for (int i = 0; i < 1000; i++) begin
         drive(1, 0, 0, 479, 1, 1, 1, 200 + i, i);
         checks++; if ({wr_ready, mem_we} !== 2'b11) begin errors++; $display("FAIL stream[%0d] got %b exp 11", i, {wr_ready, mem_we}); end
      end
      drive(1, 0, 0, 479, 1, 1, 0, 0, 0);
      checks++; if (wr_count !== 16'd1000) begin errors++; $display("FAIL stream_count got %0d exp 1000", wr_count); end
      for (int x = 0; x < 4; x++) drive(1, 1, x, 479, 1, 1, 0, 0, 0);
      drive(1, 0, 0, 479, 1, 1, 1, 300, 8'h77);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL fd2 got %b exp 1", frame_done); end
      drive(1, 0, 0, 479, 1, 1, 0, 0, 0);
      checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL fd2_count got %0d exp 1", wr_count); end
   endtask

   task automatic test_oob;
      drive(1, 0, 0, 479, 1, 1, 1, 19199, 8'h11);
      checks++; if ({wr_ready, mem_we} !== 2'b11) begin errors++; $display("FAIL last_legal got %b exp 11", {wr_ready, mem_we}); end
      drive(1, 0, 0, 479, 1, 1, 1, 19200, 8'h22);
      checks++; if ({wr_ready, mem_we, err_oob} !== 3'b100) begin errors++; $display("FAIL oob got %b exp 100", {wr_ready, mem_we, err_oob}); end
      checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL oob_count_pre got %0d exp 2", wr_count); end
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 479, 1, 1, 0, 0, 0);
         checks++; if (err_oob !== 1'b1 || wr_count !== 16'd2)
            begin errors++; $display("FAIL oob_sticky[%0d] got err=%b count=%0d exp 1/2", i, err_oob, wr_count); end
      end
   endtask

   task automatic test_frame;
      logic hq [0:2];
      logic vq [0:2];
      logic aq [0:2];
      logic a, h, v;
      int fd_n;
      for (int k = 0; k < 3; k++) begin hq[k] = 1'b1; vq[k] = 1'b1; aq[k] = 1'b0; end
      for (int f = 0; f < 2; f++) begin
         fd_n = 0;
         for (int ln = 0; ln < 7; ln++) begin
            for (int c = 0; c < 14; c++) begin
               a = (ln < 4) && (c < 8);
               h = !(c == 10 || c == 11);
               v = (ln != 5);
               hq[2] = hq[1]; hq[1] = hq[0]; hq[0] = h;
               vq[2] = vq[1]; vq[1] = vq[0]; vq[0] = v;
               aq[2] = aq[1]; aq[1] = aq[0]; aq[0] = a;
               drive(1, a, a ? c : 0, ln < 4 ? 476 + ln : 479, h, v, 0, 0, 0);
               if (frame_done === 1'b1) fd_n++;
               checks++; if ({hsync_d, vsync_d, active_d} !== {hq[2], vq[2], aq[2]})
                  begin errors++; $display("FAIL sync_d f%0d l%0d c%0d got %b exp %b", f, ln, c, {hsync_d, vsync_d, active_d}, {hq[2], vq[2], aq[2]}); end
            end
         end
         checks++; if (fd_n !== 1) begin errors++; $display("FAIL frame_pulses[%0d] got %0d exp 1", f, fd_n); end
      end
      checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_end got %b exp 1", err_oob); end
   endtask

   initial begin
      test_reset;
      test_preload;
      test_pixels;
      test_reset_midline;
      test_collision;
      test_back_to_back;
      test_oob;
      test_frame;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
